// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared constants and types for the four-bit ALU arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ALU control encodings (ctrl[0]=0 selects AND regardless of ctrl[1])
    localparam logic [1:0] CTRL_AND = 2'b00;
    localparam logic [1:0] CTRL_ADD = 2'b01;
    localparam logic [1:0] CTRL_SUB = 2'b11;

    // Requester identifiers, also used as the winner / priority encoding
    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // Single-entry response register occupancy
    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/four_bit_alu.sv
`default_nettype none
// ============================================================================
// Module      : four_bit_alu
// Description : Combinational 4-bit AND / ADD / SUB with signed overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module four_bit_alu
    import alu_pkg::*;
(
    input  logic [3:0] opA,
    input  logic [3:0] opB,
    input  logic [1:0] ctrl,
    output logic [3:0] Result,
    output logic       Overflow
);

    logic [3:0] sum;
    logic [3:0] diff;

    assign sum  = opA + opB;
    assign diff = opA - opB;

    // Operation select; overflow only meaningful for add/sub, forced low for AND
    always_comb begin
        Result   = 4'b0000;
        Overflow = 1'b0;
        case (ctrl)
            CTRL_ADD: begin
                Result   = sum;
                Overflow = (opA[3] == opB[3]) && (sum[3] != opA[3]);
            end
            CTRL_SUB: begin
                Result   = diff;
                Overflow = (opA[3] != opB[3]) && (diff[3] != opA[3]);
            end
            default: begin
                // CTRL_AND and 2'b10 both decode as AND
                Result   = opA & opB;
                Overflow = 1'b0;
            end
        endcase
    end

endmodule : four_bit_alu
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin arbiter sharing one four_bit_alu between two
//               requesters, with a single-entry valid/ready response register
//               and saturating per-requester grant counters.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int CNT_W = 8
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_opA,
    input  logic [3:0]       req0_opB,
    input  logic [1:0]       req0_ctrl,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_opA,
    input  logic [3:0]       req1_opB,
    input  logic [1:0]       req1_ctrl,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_result,
    output logic             rsp_overflow,
    output logic             rsp_id,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);

    rsp_state_t state;
    rsp_state_t next_state;
    logic       prio;
    logic       winner;
    logic       slot_free;
    logic       accept0;
    logic       accept1;
    logic       accept;
    logic [3:0] alu_opA;
    logic [3:0] alu_opB;
    logic [1:0] alu_ctrl;
    logic [3:0] alu_result;
    logic       alu_overflow;

    // Winner selection: a lone requester wins, contention resolved by prio
    always_comb begin
        winner = REQ0;
        if (req0_valid && req1_valid) begin
            winner = prio;
        end else if (req1_valid) begin
            winner = REQ1;
        end
    end

    // The slot can take a new result if empty or being drained this cycle.
    // rst_n gating keeps both readies low while reset is held.
    assign slot_free  = ~rsp_valid | rsp_ready;
    assign req0_ready = rst_n & slot_free & (winner == REQ0) & req0_valid;
    assign req1_ready = rst_n & slot_free & (winner == REQ1) & req1_valid;
    assign accept0    = req0_valid & req0_ready;
    assign accept1    = req1_valid & req1_ready;
    assign accept     = accept0 | accept1;

    assign alu_opA  = (winner == REQ1) ? req1_opA  : req0_opA;
    assign alu_opB  = (winner == REQ1) ? req1_opB  : req0_opB;
    assign alu_ctrl = (winner == REQ1) ? req1_ctrl : req0_ctrl;

    four_bit_alu u_alu (
        .opA      (alu_opA),
        .opB      (alu_opB),
        .ctrl     (alu_ctrl),
        .Result   (alu_result),
        .Overflow (alu_overflow)
    );

    // Response register occupancy state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RSP_EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // Next occupancy: fill on accept, empty only on a drain without refill
    always_comb begin
        next_state = state;
        case (state)
            RSP_EMPTY: if (accept) next_state = RSP_FULL;
            RSP_FULL:  if (rsp_ready && !accept) next_state = RSP_EMPTY;
            default:   next_state = RSP_EMPTY;
        endcase
    end

    assign rsp_valid = (state == RSP_FULL);

    // Response payload and round-robin pointer update on every accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result   <= 4'b0000;
            rsp_overflow <= 1'b0;
            rsp_id       <= REQ0;
            prio         <= REQ0;
        end else if (accept) begin
            rsp_result   <= alu_result;
            rsp_overflow <= alu_overflow;
            rsp_id       <= winner;
            prio         <= ~winner;
        end
    end

    // Saturating grant counters; hold at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (accept0 && (grant_cnt0 != '1)) begin
                grant_cnt0 <= grant_cnt0 + CNT_W'(1);
            end
            if (accept1 && (grant_cnt1 != '1)) begin
                grant_cnt1 <= grant_cnt1 + CNT_W'(1);
            end
        end
    end

endmodule : alu_arbiter
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed, table-driven self-checking bench for alu_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid, rsp_ready;
    logic [3:0] req0_opA, req0_opB, req1_opA, req1_opB;
    logic [1:0] req0_ctrl, req1_ctrl;
    logic       req0_ready, req1_ready, rsp_valid, rsp_overflow, rsp_id;
    logic [3:0] rsp_result;
    logic [7:0] grant_cnt0, grant_cnt1;
    // second instance with narrow counters shares all inputs
    logic       s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_overflow, s_rsp_id;
    logic [3:0] s_rsp_result;
    logic [1:0] s_grant_cnt0, s_grant_cnt1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_opA(req0_opA), .req0_opB(req0_opB), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_opA(req1_opA), .req1_opB(req1_opB), .req1_ctrl(req1_ctrl),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_overflow(rsp_overflow), .rsp_id(rsp_id),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    alu_arbiter #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(s_req0_ready),
        .req0_opA(req0_opA), .req0_opB(req0_opB), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(s_req1_ready),
        .req1_opA(req1_opA), .req1_opB(req1_opB), .req1_ctrl(req1_ctrl),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(s_rsp_result), .rsp_overflow(s_rsp_overflow), .rsp_id(s_rsp_id),
        .grant_cnt0(s_grant_cnt0), .grant_cnt1(s_grant_cnt1)
    );

    typedef struct {
        logic       v0;
        logic [3:0] a0;
        logic [3:0] b0;
        logic [1:0] c0;
        logic       v1;
        logic [3:0] a1;
        logic [3:0] b1;
        logic [1:0] c1;
        logic       rr;
        logic       e_rdy0;
        logic       e_rdy1;
        logic       e_valid;
        logic       chk_data;
        logic [3:0] e_res;
        logic       e_ovf;
        logic       e_id;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v0, input logic [3:0] a0, input logic [3:0] b0,
                         input logic [1:0] c0, input logic v1, input logic [3:0] a1,
                         input logic [3:0] b1, input logic [1:0] c1, input logic rr);
        req0_valid = v0; req0_opA = a0; req0_opB = b0; req0_ctrl = c0;
        req1_valid = v1; req1_opA = a1; req1_opB = b1; req1_ctrl = c1;
        rsp_ready  = rr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // contention: req0 AND 1100&1010=1000, req1 SUB 1000-0001=0111 ovf
        tbl[0]  = '{1'b1,4'hC,4'hA,2'b00, 1'b1,4'h8,4'h1,2'b11, 1'b1, 1'b1,1'b0, 1'b1,1'b1, 4'h8,1'b0,1'b0};
        tbl[1]  = '{1'b1,4'hC,4'hA,2'b00, 1'b1,4'h8,4'h1,2'b11, 1'b1, 1'b0,1'b1, 1'b1,1'b1, 4'h7,1'b1,1'b1};
        tbl[2]  = '{1'b1,4'hC,4'hA,2'b00, 1'b1,4'h8,4'h1,2'b11, 1'b1, 1'b1,1'b0, 1'b1,1'b1, 4'h8,1'b0,1'b0};
        tbl[3]  = '{1'b1,4'hC,4'hA,2'b00, 1'b1,4'h8,4'h1,2'b11, 1'b1, 1'b0,1'b1, 1'b1,1'b1, 4'h7,1'b1,1'b1};
        // single requester add 0111+0001 = 1000 with overflow
        tbl[4]  = '{1'b1,4'h7,4'h1,2'b01, 1'b0,4'h0,4'h0,2'b00, 1'b1, 1'b1,1'b0, 1'b1,1'b1, 4'h8,1'b1,1'b0};
        // ctrl=10 is AND: 1111&0110 = 0110, no overflow
        tbl[5]  = '{1'b0,4'h0,4'h0,2'b00, 1'b1,4'hF,4'h6,2'b10, 1'b1, 1'b0,1'b1, 1'b1,1'b1, 4'h6,1'b0,1'b1};
        // three stall cycles: readies low, response held
        tbl[6]  = '{1'b1,4'hC,4'hA,2'b00, 1'b1,4'h8,4'h1,2'b11, 1'b0, 1'b0,1'b0, 1'b1,1'b1, 4'h6,1'b0,1'b1};
        tbl[7]  = '{1'b1,4'hC,4'hA,2'b00, 1'b1,4'h8,4'h1,2'b11, 1'b0, 1'b0,1'b0, 1'b1,1'b1, 4'h6,1'b0,1'b1};
        tbl[8]  = '{1'b1,4'hC,4'hA,2'b00, 1'b1,4'h8,4'h1,2'b11, 1'b0, 1'b0,1'b0, 1'b1,1'b1, 4'h6,1'b0,1'b1};
        // ready returns: drain and reload in the same cycle, req0 has priority
        tbl[9]  = '{1'b1,4'hC,4'hA,2'b00, 1'b1,4'h8,4'h1,2'b11, 1'b1, 1'b1,1'b0, 1'b1,1'b1, 4'h8,1'b0,1'b0};
        // drain without accept, then stay empty
        tbl[10] = '{1'b0,4'h0,4'h0,2'b00, 1'b0,4'h0,4'h0,2'b00, 1'b1, 1'b0,1'b0, 1'b0,1'b0, 4'h0,1'b0,1'b0};
        tbl[11] = '{1'b0,4'h0,4'h0,2'b00, 1'b0,4'h0,4'h0,2'b00, 1'b0, 1'b0,1'b0, 1'b0,1'b0, 4'h0,1'b0,1'b0};
        // empty slot accepts even with rsp_ready low, then stalls
        tbl[12] = '{1'b1,4'h7,4'h1,2'b01, 1'b0,4'h0,4'h0,2'b00, 1'b0, 1'b1,1'b0, 1'b1,1'b1, 4'h8,1'b1,1'b0};
        tbl[13] = '{1'b1,4'h7,4'h1,2'b01, 1'b0,4'h0,4'h0,2'b00, 1'b0, 1'b0,1'b0, 1'b1,1'b1, 4'h8,1'b1,1'b0};

        // reset with both requesters valid: readies must stay low
        rst_n = 1'b0;
        drive(1'b1, 4'h0, 4'h0, 2'b00, 1'b1, 4'h0, 4'h0, 2'b00, 1'b1);
        tick();
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_result", 32'(rsp_result), 32'd0);
        check("reset_rsp_ovf_id", {rsp_overflow, rsp_id}, 32'd0);
        check("reset_cnts", {grant_cnt0, grant_cnt1}, 32'd0);
        check("reset_readies", {req0_ready, req1_ready}, 32'd0);
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].v0, tbl[i].a0, tbl[i].b0, tbl[i].c0,
                  tbl[i].v1, tbl[i].a1, tbl[i].b1, tbl[i].c1, tbl[i].rr);
            #1;
            check($sformatf("v%0d_req0_ready", i), 32'(req0_ready), 32'(tbl[i].e_rdy0));
            check($sformatf("v%0d_req1_ready", i), 32'(req1_ready), 32'(tbl[i].e_rdy1));
            tick();
            check($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].e_valid));
            if (tbl[i].chk_data) begin
                check($sformatf("v%0d_rsp_result", i), 32'(rsp_result), 32'(tbl[i].e_res));
                check($sformatf("v%0d_rsp_overflow", i), 32'(rsp_overflow), 32'(tbl[i].e_ovf));
                check($sformatf("v%0d_rsp_id", i), 32'(rsp_id), 32'(tbl[i].e_id));
            end
        end
        check("table_grant_cnt0", 32'(grant_cnt0), 32'd5);
        check("table_grant_cnt1", 32'(grant_cnt1), 32'd3);
        check("table_sat_cnt0", 32'(s_grant_cnt0), 32'd3);
        check("table_sat_cnt1", 32'(s_grant_cnt1), 32'd3);

        // reset mid-stall: response full, prio points at req1 before reset
        drive(1'b1, 4'hC, 4'hA, 2'b00, 1'b1, 4'h8, 4'h1, 2'b11, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check("rststall_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rststall_rsp_data", {rsp_result, rsp_overflow, rsp_id}, 32'd0);
        check("rststall_cnts", {grant_cnt0, grant_cnt1}, 32'd0);
        check("rststall_readies", {req0_ready, req1_ready}, 32'd0);
        tick();
        check("rststall_readies_held", {req0_ready, req1_ready}, 32'd0);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        #1;
        check("postrst_req0_wins", {req0_ready, req1_ready}, 32'b10);
        tick();
        check("postrst_rsp_valid", 32'(rsp_valid), 32'd1);
        check("postrst_rsp_id", 32'(rsp_id), 32'd0);
        check("postrst_rsp_result", 32'(rsp_result), 32'h8);
        check("postrst_cnt0", 32'(grant_cnt0), 32'd1);

        // counter saturation: req1 alone, five back-to-back accepts (3+4=7)
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        drive(1'b0, 4'h0, 4'h0, 2'b00, 1'b1, 4'h3, 4'h4, 2'b01, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("sat%0d_narrow_cnt1", k), 32'(s_grant_cnt1), (k < 3) ? k + 1 : 3);
            check($sformatf("sat%0d_wide_cnt1", k), 32'(grant_cnt1), k + 1);
            check($sformatf("sat%0d_rsp", k), {rsp_valid, rsp_id, rsp_result}, 32'b1_1_0111);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_alu_arbiter
`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter that shares one `four_bit_alu` instance between two requesters. Each requester presents an operation with a valid/ready handshake. The granted operation is evaluated by the ALU and captured into a single-entry response register, which drains through its own valid/ready handshake. The block sits between two independent command sources (e.g. two lab sequencers) and one downstream consumer.

## Interface
Parameters:
- `CNT_W`, default 8: width of the per-requester grant counters.

Ports:
- `clk`, in, 1: rising-edge clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req0_valid`, in, 1: requester 0 has an operation.
- `req0_ready`, out, 1: requester 0 operation accepted this cycle.
- `req0_opA`, in, 4: requester 0 operand A.
- `req0_opB`, in, 4: requester 0 operand B.
- `req0_ctrl`, in, 2: requester 0 ALU control.
- `req1_valid`, `req1_ready`, `req1_opA`, `req1_opB`, `req1_ctrl`: same as requester 0, for requester 1.
- `rsp_valid`, out, 1: response register holds a result.
- `rsp_ready`, in, 1: consumer takes the response.
- `rsp_result`, out, 4: captured ALU Result.
- `rsp_overflow`, out, 1: captured ALU Overflow.
- `rsp_id`, out, 1: requester that produced the response.
- `grant_cnt0`, out, `CNT_W`: saturating count of requester 0 acceptances.
- `grant_cnt1`, out, `CNT_W`: saturating count of requester 1 acceptances.

## Operation
- ALU control encoding:
  - ctrl[0]=0: bitwise AND; Overflow forced to 0.
  - ctrl[0]=1, ctrl[1]=0: opA+opB.
  - ctrl[0]=1, ctrl[1]=1: opA−opB.
  - Overflow is signed two's-complement overflow of the 4-bit add/sub.
- Slot free: `slot_free = ~rsp_valid | rsp_ready`.
- Arbitration (combinational, each cycle):
  - Only one valid requester: it wins.
  - Both valid: the requester named by `prio` wins.
  - `reqN_ready = slot_free & (winner == N) & reqN_valid`. The loser's ready is 0.
- Accept (a `reqN_valid & reqN_ready` handshake):
  - Winner's operands drive the ALU.
  - Result, Overflow and N are registered into the response register.
  - `rsp_valid` is set.
  - `prio` is set to the non-winner.
  - `grant_cntN` increments, saturating at all-ones.
- Drain (`rsp_valid & rsp_ready`) with no accept in the same cycle: `rsp_valid` clears. With an accept in the same cycle, the register reloads and `rsp_valid` stays 1.
- No accept: `prio` holds.
- Response register state machine, two states:
  - EMPTY (`rsp_valid=0`).
  - FULL (`rsp_valid=1`).
  - EMPTY→FULL on accept.
  - FULL→EMPTY on drain without accept.
  - FULL→FULL on drain with accept, or on stall.
- Requesters must hold operands stable while valid and not ready. Valid must not depend on ready.

## Timing
- Reset values (asynchronous, while `rst_n`=0): `rsp_valid`=0, `rsp_result`=0, `rsp_overflow`=0, `rsp_id`=0, `prio`=0, both grant counters=0. All readies read 0 during reset.
- Latency: accept in cycle t → `rsp_valid`=1 with data in cycle t+1.
- Throughput: one operation per cycle when `rsp_ready` is held 1.
- `reqN_ready` has a combinational path from `rsp_ready`, `req0_valid` and `req1_valid`. There are no other comb paths input→output.
- Stall: `rsp_valid`=1 and `rsp_ready`=0 → both readies 0; response outputs hold unchanged.
- Reset asserted mid-transaction: an un-drained response is discarded and is not replayed.
- Counters saturate and do not wrap: at all-ones, further accepts leave the value unchanged.

## Structure
- Shared package `alu_pkg`:
  - localparams `CTRL_AND`=2'b00, `CTRL_ADD`=2'b01, `CTRL_SUB`=2'b11.
  - Requester id constants `REQ0`=1'b0, `REQ1`=1'b1.
- Sub-module: one instance of the existing `four_bit_alu`, fed by a 2:1 operand/ctrl mux on the winner.
- Arbitration, response register and counters are inline.

## Test plan
- Single requester:
  - Stimulus: req0 opA=4'b0111, opB=4'b0001, ctrl=01; `rsp_ready`=1.
  - Response: next cycle `rsp_result`=4'b1000, `rsp_overflow`=1, `rsp_id`=0; `grant_cnt0`=1.
- Contention with alternation:
  - Stimulus: both valid continuously, `rsp_ready`=1. req0 ctrl=00, 1100/1010; req1 ctrl=11, 1000/0001.
  - Response: ids alternate 0,1,0,1… starting with 0. Results alternate 4'b1000 (ovf 0) and 4'b0111 (ovf 1).
- Backpressure:
  - Stimulus: `rsp_ready`=0 for 3 cycles after the first accept.
  - Response: both readies 0; `rsp_result` is stable. When `rsp_ready` returns to 1, the next accept occurs in that same cycle and the response reloads with no bubble.
- AND masks overflow:
  - Stimulus: ctrl=10, opA=4'b1111, opB=4'b0110.
  - Response: `rsp_result`=4'b0110, `rsp_overflow`=0.
- Counter saturation:
  - Stimulus: `CNT_W`=2, req1 alone, 5 accepts.
  - Response: `grant_cnt1` reads 1,2,3,3,3.
- Reset mid-stall:
  - Stimulus: `rsp_valid`=1, `rsp_ready`=0, then pulse `rst_n` low.
  - Response: `rsp_valid`, counters and `prio` go to 0 immediately. After release, if both requesters are valid, req0 wins first.
